// File: rtl/pitch_detect_pkg.sv
// Shared types and default constants for the pitch-detect SNR gate sequencer.
package pitch_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAL     = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_MONITOR = 2'd3
  } snr_gate_state_e;

  localparam int DEF_SNR_WIDTH      = 16;
  localparam int DEF_CAL_SAMPLES    = 4096;
  localparam int DEF_SETTLE_SAMPLES = 256;
  localparam int DEF_ON_THRESH_DB   = 12;
  localparam int DEF_OFF_THRESH_DB  = 6;
  localparam int DEF_HOLD_SAMPLES   = 480;
  localparam int DEF_RECAL_SAMPLES  = 48000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hold_counter.sv
// Saturating run-length counter: counts qualifying enabled samples, clears on a
// non-qualifying one, and pulses o_tc (combinationally) on the TERMINAL-th in a row.
module hold_counter #(
  parameter int W        = 8,
  parameter int TERMINAL = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  input  logic i_qual,
  input  logic i_clr,
  output logic o_tc
);

  logic [W-1:0] r_cnt;
  logic         w_tc;

  assign w_tc = i_en & i_qual & (r_cnt == W'(TERMINAL - 1));
  assign o_tc = w_tc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr || w_tc) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (!i_qual)
        r_cnt <= '0;
      else if (r_cnt != {W{1'b1}})
        r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/snr_gate_ctrl.sv
// Calibration sequencer and hysteretic, debounced signal_present gate.
// Optional build macro SNR_GATE_AUTO_RECAL_EN adds auto-recal after a long silence.
//
// state   | meaning
// IDLE    | waiting for start
// CAL     | quiet_period high, counting CAL_SAMPLES valid samples
// SETTLE  | counting SETTLE_SAMPLES valid samples, gate held low
// MONITOR | debouncing snr_db into signal_present
module snr_gate_ctrl
  import pitch_detect_pkg::*;
#(
  parameter int SNR_WIDTH      = DEF_SNR_WIDTH,
  parameter int CAL_SAMPLES    = DEF_CAL_SAMPLES,
  parameter int SETTLE_SAMPLES = DEF_SETTLE_SAMPLES,
  parameter int ON_THRESH_DB   = DEF_ON_THRESH_DB,
  parameter int OFF_THRESH_DB  = DEF_OFF_THRESH_DB,
  parameter int HOLD_SAMPLES   = DEF_HOLD_SAMPLES,
  parameter int RECAL_SAMPLES  = DEF_RECAL_SAMPLES
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        recal_req,
  input  logic                        sample_valid,
  input  logic signed [SNR_WIDTH-1:0] snr_db,
  input  logic                        snr_valid,
  output logic                        quiet_period,
  output logic                        cal_done,
  output logic                        signal_present,
  output logic                        gate_edge,
  output logic [1:0]                  state
);

  localparam int CW = $clog2(max_int(max_int(CAL_SAMPLES, SETTLE_SAMPLES),
                                     max_int(HOLD_SAMPLES, RECAL_SAMPLES))) + 1;
  localparam logic signed [SNR_WIDTH-1:0] ON_T  = SNR_WIDTH'(ON_THRESH_DB);
  localparam logic signed [SNR_WIDTH-1:0] OFF_T = SNR_WIDTH'(OFF_THRESH_DB);

  snr_gate_state_e r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_cal_done, w_cal_done_nxt;
  logic            r_gate, w_gate_nxt;
  logic            r_quiet, r_edge;

  logic w_mon, w_recal, w_hold_en, w_hold_qual, w_hold_clr, w_hold_tc, w_idle_tc;

  assign w_mon       = (r_state == ST_MONITOR);
  assign w_hold_en   = w_mon & snr_valid;
  assign w_hold_qual = r_gate ? (snr_db < OFF_T) : (snr_db >= ON_T);
  assign w_recal     = recal_req | w_idle_tc;
  assign w_hold_clr  = ~w_mon | w_recal;

  hold_counter #(.W(CW), .TERMINAL(HOLD_SAMPLES)) u_hold (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (w_hold_en),
    .i_qual  (w_hold_qual),
    .i_clr   (w_hold_clr),
    .o_tc    (w_hold_tc)
  );

`ifdef SNR_GATE_AUTO_RECAL_EN
  logic w_idle_clr;
  // The idle counter clears itself on its own terminal count, so only the
  // external request feeds its clear (avoids a loop through w_recal).
  assign w_idle_clr = ~w_mon | recal_req;

  hold_counter #(.W(CW), .TERMINAL(RECAL_SAMPLES)) u_idle (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (w_hold_en),
    .i_qual  (~r_gate),
    .i_clr   (w_idle_clr),
    .o_tc    (w_idle_tc)
  );
`else
  assign w_idle_tc = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_cal_done_nxt = r_cal_done;
    w_gate_nxt     = r_gate;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_CAL;
          w_cnt_nxt   = '0;
        end
      end
      ST_CAL: begin
        if (recal_req) begin
          w_cnt_nxt = '0;
        end else if (sample_valid) begin
          if (r_cnt == CW'(CAL_SAMPLES - 1)) begin
            w_state_nxt    = ST_SETTLE;
            w_cal_done_nxt = 1'b1;
            w_cnt_nxt      = '0;
          end else if (r_cnt != {CW{1'b1}}) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        w_gate_nxt = 1'b0;
        if (recal_req) begin
          w_state_nxt = ST_CAL;
          w_cnt_nxt   = '0;
        end else if (sample_valid) begin
          if (r_cnt == CW'(SETTLE_SAMPLES - 1)) begin
            w_state_nxt = ST_MONITOR;
            w_cnt_nxt   = '0;
          end else if (r_cnt != {CW{1'b1}}) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      ST_MONITOR: begin
        if (w_recal) begin
          w_state_nxt = ST_CAL;
          w_cnt_nxt   = '0;
          w_gate_nxt  = 1'b0;
        end else if (w_hold_tc) begin
          w_gate_nxt = ~r_gate;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_cal_done <= 1'b0;
      r_gate     <= 1'b0;
      r_quiet    <= 1'b0;
      r_edge     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cal_done <= w_cal_done_nxt;
      r_gate     <= w_gate_nxt;
      r_quiet    <= (w_state_nxt == ST_CAL);
      r_edge     <= w_gate_nxt ^ r_gate;
    end
  end

  assign quiet_period   = r_quiet;
  assign cal_done       = r_cal_done;
  assign signal_present = r_gate;
  assign gate_edge      = r_edge;
  assign state          = r_state;

endmodule

// File: doc/snr_gate_ctrl.md
# snr_gate_ctrl

Sequencer and decision stage around the SNR calculator in the pitch-detect path. It runs the noise-floor calibration by driving `quiet_period` for a fixed number of audio samples, then waits out a settling window. After that it turns the streamed `snr_db` into a debounced, hysteretic `signal_present` gate, which the pitch detector uses to qualify its outputs. Recalibration can be requested at any time, and optionally fires automatically after a long silence.

## Interface
Parameters:
- `SNR_WIDTH`, 16, width of `snr_db`; signed, integer dB.
- `CAL_SAMPLES`, 4096, number of valid samples with `quiet_period` high per calibration.
- `SETTLE_SAMPLES`, 256, number of valid samples after calibration before gating starts.
- `ON_THRESH_DB`, 12, signed; `snr_db >= ON_THRESH_DB` counts toward turn-on.
- `OFF_THRESH_DB`, 6, signed; `snr_db < OFF_THRESH_DB` counts toward turn-off. Must be ≤ `ON_THRESH_DB`.
- `HOLD_SAMPLES`, 480, number of consecutive qualifying samples needed to change the gate.
- `RECAL_SAMPLES`, 48000, number of consecutive off-gate samples before auto-recalibration (macro only).

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  pulse; begins calibration from IDLE.
- `recal_req`  in  1  pulse; forces recalibration from SETTLE or MONITOR.
- `sample_valid`  in  1  one audio sample accepted this cycle.
- `snr_db`  in  SNR_WIDTH  signed SNR in dB, valid on `snr_valid`.
- `snr_valid`  in  1  `snr_db` is valid this cycle.
- `quiet_period`  out  1  high while calibrating; drives the SNR calculator.
- `cal_done`  out  1  level; high once calibration has completed at least once since reset.
- `signal_present`  out  1  debounced gate.
- `gate_edge`  out  1  one-cycle pulse on every `signal_present` change.
- `state`  out  2  current FSM state encoding.

## Operation
- States: IDLE=0, CAL=1, SETTLE=2, MONITOR=3.
- IDLE: `start` moves to CAL. `recal_req` is ignored.
- CAL: `quiet_period`=1; the sample counter increments on each `sample_valid`. When the counter reaches `CAL_SAMPLES`-1 and `sample_valid` is high: go to SETTLE, set `cal_done`, clear the counter.
- SETTLE: the counter increments on `sample_valid`. At `SETTLE_SAMPLES`-1, go to MONITOR. `signal_present` is held at 0.
- MONITOR, on each `snr_valid`:
  - Gate off: the on-count increments while `snr_db >= ON_THRESH_DB` and clears otherwise. At `HOLD_SAMPLES`-1, set `signal_present` and clear the count.
  - Gate on: the same rule applies with `snr_db < OFF_THRESH_DB` and an off-count, clearing `signal_present` at the end.
  - Values between the two thresholds clear both counts.
- `recal_req` in SETTLE or MONITOR: go to CAL next cycle. All counters clear. `signal_present` drops to 0 (with `gate_edge` if it was 1). `cal_done` keeps its value.
- `recal_req` during CAL restarts the CAL count from 0.
- `start` outside IDLE is ignored.
- `start` and `recal_req` in the same cycle in IDLE: `start` wins.
- Comparisons are signed, with thresholds sign-extended to `SNR_WIDTH`.
- Counter width is `$clog2` of the largest count parameter plus 1. Counters saturate and never wrap.

## Timing
- Reset values: `state`=IDLE; `quiet_period`, `cal_done`, `signal_present`, `gate_edge` all 0; all counters 0.
- All outputs are registered. `quiet_period` rises on the clock edge that enters CAL, which is 1 cycle after `start`.
- `quiet_period` falls on the edge after the `CAL_SAMPLES`-th valid sample.
- The gate changes on the edge after the `HOLD_SAMPLES`-th qualifying `snr_valid`. `gate_edge` is high for exactly that cycle.
- Asserting `reset_n` low mid-operation returns every output to its reset value immediately, with no pulse on `gate_edge`.
- `sample_valid` and `snr_valid` may be high every cycle. There is no backpressure.

## Configuration
- Macro `SNR_GATE_AUTO_RECAL_EN`.
- Defined: in MONITOR, an idle counter increments on each `snr_valid` while `signal_present`=0 and clears when `signal_present`=1. At `RECAL_SAMPLES`-1 the block acts as if `recal_req` was asserted.
- Undefined: the idle counter and `RECAL_SAMPLES` logic are absent. Recalibration happens only through `recal_req`.

## Structure
- Package `pitch_detect_pkg`: state enum `snr_gate_state_e` (2-bit) and default constants for the thresholds and sample counts.
- Sub-module `hold_counter`: saturating counter with a qualify/clear input and a terminal-count pulse. It is instantiated once for on/off debounce and once for auto-recal. The FSM and gate register stay in the top.

## Test plan
- Calibration: with `CAL_SAMPLES`=8, `start`, then 8 `sample_valid` pulses with gaps → `quiet_period` high for exactly that window; `state` reads 2 and `cal_done`=1 on the edge after the 8th pulse.
- Turn on: with `HOLD_SAMPLES`=4, in MONITOR drive `snr_db`=15 for 4 `snr_valid` → `signal_present`=1 and a one-cycle `gate_edge`. 3 samples at 15 followed by one at 9 → the gate stays 0.
- Hysteresis: gate on; `snr_db`=8 (between thresholds) for 10 samples → gate stays 1. Then `snr_db`=-3 for 4 samples → gate 0 with a `gate_edge` pulse.
- Recalibration: `recal_req` in MONITOR with gate on → next cycle `state`=1, `quiet_period`=1, `signal_present`=0, `gate_edge` pulse, `cal_done` still 1.
- Reset: drop `reset_n` in the middle of CAL → all outputs 0 and `state`=0 asynchronously. After release, `start` is required before `quiet_period` rises again.
- Auto-recal (macro on, `RECAL_SAMPLES`=16): 16 `snr_valid` at 0 dB with gate off → `state`=1. With the macro off, the same stimulus leaves `state`=3.
